// File: rtl/fp_link_arb.sv
// fp_link_arb: two-channel four-phase dual-rail to single-rail arbiter.
// Each channel is synchronized, checked for complete/empty over two
// consecutive cycles, then arbitrated round-robin onto a valid/ready port.

// Per-channel receiver: rail synchronizer, per-bit null history, decode.
module fp_link_rx #(
  parameter int WIDTH       = 8,
  parameter int RAIL_NUM    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0] rails,
  output logic                           complete,
  output logic                           empty,
  output logic                           illegal,
  output logic [WIDTH-1:0]               data
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0][RAIL_NUM-1:0] sync_q;
  logic [WIDTH-1:0] nn_cur, nn_prev, ill;

  // Synchronizer chain per rail plus one cycle of non-null history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      nn_prev <= '0;
    end else begin
      sync_q[0] <= rails;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      nn_prev <= nn_cur;
    end
  end

  // Per-bit decode of the synchronized word; 2'b11 counts as non-null.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign nn_cur[b] = |sync_q[SYNC_STAGES-1][b];
    assign ill[b]    = &sync_q[SYNC_STAGES-1][b];
    assign data[b]   = sync_q[SYNC_STAGES-1][b][1];
  end

  assign complete = (&nn_cur) & (&nn_prev);
  assign empty    = ~(|nn_cur) & ~(|nn_prev);
  assign illegal  = |ill;
endmodule

module fp_link_arb #(
  parameter int WIDTH       = 8,
  parameter int RAIL_NUM    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0] in0,
  output logic                           ack0_o,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0] in1,
  output logic                           ack1_o,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_src,
  output logic                           err
);
  typedef enum logic [1:0] {IDLE, OUT, ACK} state_t;

  state_t state;
  logic [1:0][WIDTH-1:0][RAIL_NUM-1:0] ch_in;
  logic [1:0]            complete, empty, illegal;
  logic [1:0][WIDTH-1:0] data;
  logic                  prio, pick;

  assign ch_in = {in1, in0};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    fp_link_rx #(
      .WIDTH(WIDTH), .RAIL_NUM(RAIL_NUM), .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
      .clk(clk), .rst(rst), .rails(ch_in[c]),
      .complete(complete[c]), .empty(empty[c]),
      .illegal(illegal[c]), .data(data[c])
    );
  end

  // Both complete: the pointer decides; otherwise the lone complete channel.
  assign pick = (complete[0] & complete[1]) ? prio : complete[1];

  // Handshake FSM; out_src doubles as the grant held through OUT and ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      ack0_o    <= 1'b0;
      ack1_o    <= 1'b0;
      err       <= 1'b0;
      prio      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|complete) begin
          state     <= OUT;
          out_valid <= 1'b1;
          out_data  <= data[pick];
          out_src   <= pick;
          prio      <= ~pick;
          if (illegal[pick]) err <= 1'b1;
        end
        OUT: if (out_ready) begin
          state     <= ACK;
          out_valid <= 1'b0;
          if (out_src) ack1_o <= 1'b1;
          else         ack0_o <= 1'b1;
        end
        ACK: if (empty[out_src]) begin
          state  <= IDLE;
          ack0_o <= 1'b0;
          ack1_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_link_arb.md
FP_LINK_ARB -- requirements
Module: fp_link_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-002 The block SHALL have parameter RAIL_NUM, default 2, meaning rails per bit; only value 2 is supported.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per rail (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in0, input, [WIDTH-1:0][RAIL_NUM-1:0]: four-phase dual-rail channel 0.
REQ-007 The block SHALL have port ack0_o, output, 1 bit: acknowledge for channel 0.
REQ-008 The block SHALL have port in1, input, [WIDTH-1:0][RAIL_NUM-1:0]: four-phase dual-rail channel 1.
REQ-009 The block SHALL have port ack1_o, output, 1 bit: acknowledge for channel 1.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: decoded single-rail word.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the word.
REQ-013 The block SHALL have port out_src, output, 1 bit: source channel of out_data (0 or 1).
REQ-014 The block SHALL have port err, output, 1 bit: sticky flag for an illegal rail code.

Function
REQ-015 Rail encoding per bit SHALL be: 2'b00 = null, 2'b01 = logic 0, 2'b10 = logic 1, 2'b11 = illegal.
REQ-016 Each rail of in0 and in1 SHALL pass through SYNC_STAGES flops before any use; every later reference to a channel state means its synchronized value.
REQ-017 A channel SHALL be "complete" when every bit is non-null in the current cycle and also was in the previous cycle.
REQ-018 A channel SHALL be "empty" when every bit is null in the current cycle and also was in the previous cycle.
REQ-019 A word that mixes null and non-null bits SHALL never be captured or acknowledged.
REQ-020 The FSM SHALL have three states (IDLE, OUT, ACK) with the following transitions:
- IDLE -> OUT when at least one channel is complete.
- OUT -> ACK on the rising edge where out_valid && out_ready.
- ACK -> IDLE when the granted channel is empty.
REQ-021 On the IDLE->OUT edge the block SHALL register the granted channel's word into out_data (bit = rail[1]) and set out_src to the grant.
REQ-022 out_valid SHALL be 1 exactly while the FSM is in OUT, and out_data/out_src SHALL stay stable throughout OUT.
REQ-023 If exactly one channel is complete in IDLE, that channel SHALL be granted.
REQ-024 If both channels are complete in IDLE, the channel not served last SHALL be granted; the priority pointer SHALL update on every grant.
REQ-025 ackN_o SHALL be registered, equal to 1 exactly while the FSM is in ACK with grant N, and the ungranted channel's ack SHALL stay 0.
REQ-026 The latency from the raw inputs becoming complete and stable (FSM in IDLE, channel wins) to out_valid=1 SHALL be exactly SYNC_STAGES+2 rising edges.
REQ-027 The ACK->IDLE edge SHALL drop ackN_o to 0; the earliest next grant SHALL be at the following edge.
REQ-028 A bit equal to 2'b11 SHALL count as non-null for completion; if any bit of the captured word is 2'b11, err SHALL set to 1 on the capture edge and hold until reset.
REQ-029 A channel that is complete while the other is being served SHALL wait without loss, since the producer holds data until it is acknowledged.
REQ-030 out_ready asserted outside OUT SHALL have no effect.

Reset
REQ-031 When rst=1 at a rising edge, the following SHALL apply:
- FSM goes to IDLE; all synchronizer and history flops go to null.
- out_valid=0, out_data=0, out_src=0, ack0_o=0, ack1_o=0, err=0.
- Priority pointer favours channel 0.
REQ-032 Reset asserted in OUT or ACK SHALL abort the transfer without output, and a word still presented SHALL be re-captured after reset as a new transfer.
REQ-033 From the first edge after rst=0, normal operation SHALL resume with the same latency as REQ-026.

Verification
REQ-034 The bench SHALL cover a single transfer: in0 = 0xA5 dual-rail, out_ready=1 -> out_valid at edge SYNC_STAGES+2, out_data=0xA5, out_src=0, then ack0_o=1; in0 nulled -> ack0_o=0.
REQ-035 The bench SHALL cover simultaneous requests: in0=0x11 and in1=0x22 complete in the same cycle after reset -> outputs 0x11 (src 0), then 0x22 (src 1); repeated -> 0x22 first is not allowed, order alternates (ch1 then ch0 on the next pair if ch1 was not served last).
REQ-036 The bench SHALL cover backpressure: out_ready=0 for 10 cycles while in OUT -> out_valid stays 1, out_data stable, ack0_o=0; out_ready=1 -> ack0_o=1 the next cycle.
REQ-037 The bench SHALL cover skewed arrival: the in1 bits go non-null one per cycle over 8 cycles -> no capture until all 8 bits are valid, and the captured value equals the final word.
REQ-038 The bench SHALL cover an illegal code: in0 bit3 = 2'b11, others valid -> the word is delivered with bit3=1, err=1 and stays 1 after further good transfers until rst.
REQ-039 The bench SHALL cover reset mid-ACK: rst pulsed while ack1_o=1 -> all outputs 0 next cycle, and a still-present in1 word is re-delivered after reset.
